// File: rtl/uart_tx_arbiter.sv
// Frame-level arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 64,
  parameter int FRAME_GAP    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 tx_busy,
  output logic [7:0]           write_data,
  output logic                 write_en,
  output logic                 arb_busy,
  output logic                 err_timeout
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [7:0] TO_END = 8'(BUSY_TIMEOUT - 1);
  localparam logic [7:0] GAP_END = 8'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, win;
  logic [7:0] cnt, cnt_n;
  logic last_q, last_n;
  logic found;
  logic done_exit;
  logic [7:0] sel_data;
  logic sel_last;
  logic [NUM_REQ-1:0] rdy_n, grant_n;
  logic [7:0] wdata_n;
  logic we_n, busy_n, err_n;

  // Later loop iterations overwrite earlier ones, so the
  // highest-priority candidate is visited last.
  always_comb begin
    found = 1'b0;
    win = ptr;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        found = 1'b1;
        win = PW'(j);
      end
    end
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
`endif
  end

  always_comb begin
    sel_data = 8'h00;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    last_n = last_q;
    grant_n = grant;
    wdata_n = write_data;
    rdy_n = '0;
    we_n = 1'b0;
    err_n = 1'b0;
    done_exit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|req_valid) state_n = S_ARB;
      end
      S_ARB: begin
        if (found) begin
          grant_n = '0;
          grant_n[win] = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
          ptr_n = win;
`endif
          rdy_n = grant_n & req_valid;
          state_n = S_LOAD;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD: begin
        if (|(req_valid & req_ready)) begin
          wdata_n = sel_data;
          last_n = sel_last;
          we_n = 1'b1;
          cnt_n = 8'd0;
          state_n = S_SEND;
        end else begin
          rdy_n = grant & req_valid;
        end
      end
      S_SEND: begin
        cnt_n = cnt + 8'd1;
        state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = S_WAIT_DONE;
        end else if (cnt >= TO_END) begin
          err_n = 1'b1;
          done_exit = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) done_exit = 1'b1;
      end
      S_GAP: begin
        if (cnt >= GAP_END) state_n = S_IDLE;
        else cnt_n = cnt + 8'd1;
      end
      default: state_n = S_IDLE;
    endcase
    // Shared end-of-byte path: next byte of the frame, or release.
    if (done_exit) begin
      if (last_q) begin
        grant_n = '0;
        cnt_n = 8'd0;
        state_n = (FRAME_GAP == 0) ? S_IDLE : S_GAP;
      end else begin
        rdy_n = grant & req_valid;
        state_n = S_LOAD;
      end
    end
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr <= PW'(NUM_REQ - 1);
      cnt <= 8'd0;
      last_q <= 1'b0;
      req_ready <= '0;
      grant <= '0;
      write_data <= 8'h00;
      write_en <= 1'b0;
      arb_busy <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      last_q <= last_n;
      req_ready <= rdy_n;
      grant <= grant_n;
      write_data <= wdata_n;
      write_en <= we_n;
      arb_busy <= busy_n;
      err_timeout <= err_n;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level arbiter that shares a single UART transmitter between several byte-stream requesters, such as a periodic banner generator and a loopback/echo path. Each requester presents a frame as a sequence of bytes with a last flag. The arbiter grants one whole frame at a time, so frames are never interleaved. It drives the transmitter's `write_data`/`write_en` pair and paces bytes off the transmitter's `tx_busy`.

## Interface
- `NUM_REQ`, 2 — number of requesters; legal range 2..8.
- `BUSY_TIMEOUT`, 64 — cycles to wait for `tx_busy` to rise after `write_en`; legal range 1..255.
- `FRAME_GAP`, 16 — idle cycles between the end of one frame and the next arbitration; legal range 0..255.
- `clk` in 1 — single clock.
- `rst` in 1 — asynchronous, active-high reset.
- `req_valid` in NUM_REQ — requester i has a byte available.
- `req_data` in 8*NUM_REQ — byte of requester i, carried in bits [8i+7:8i].
- `req_last` in NUM_REQ — the byte of requester i is the final byte of its frame.
- `req_ready` out NUM_REQ — byte accepted; the transfer occurs on a cycle where `req_valid[i] & req_ready[i]`.
- `grant` out NUM_REQ — one-hot; identifies the requester owning the current frame.
- `tx_busy` in 1 — transmitter is shifting a byte.
- `write_data` out 8 — byte to the transmitter.
- `write_en` out 1 — one-cycle load strobe to the transmitter.
- `arb_busy` out 1 — high in every state except IDLE.
- `err_timeout` out 1 — one-cycle pulse when `tx_busy` does not rise within `BUSY_TIMEOUT` cycles.

## Operation
- All outputs are registered. Reset values: `req_ready` 0, `grant` 0, `write_data` 8'h00, `write_en` 0, `arb_busy` 0, `err_timeout` 0. The state resets to IDLE and the round-robin pointer resets to NUM_REQ-1.
- **IDLE**: when any `req_valid` bit is high, go to ARB.
- **ARB**: one cycle. Search `req_valid` starting at pointer+1, wrapping modulo NUM_REQ, and take the first high bit. Set `grant` and the pointer to the winner, then go to LOAD. If `req_valid` has dropped to all-zero, return to IDLE.
- **LOAD**: `req_ready[g]` is high only while `req_valid[g]` is high; all other `req_ready` bits are 0. On acceptance, capture the data and last flag and go to SEND. If the granted requester deasserts valid mid-frame, stay in LOAD and keep the grant; there is no preemption. Requesters must complete frames they have started.
- **SEND**: `write_en` = 1 for exactly one cycle and `write_data` holds the captured byte. Go to WAIT_BUSY.
- **WAIT_BUSY**: a counter runs from 0. When `tx_busy` = 1, go to WAIT_DONE. When the counter reaches BUSY_TIMEOUT, pulse `err_timeout`, treat the byte as sent, and take the WAIT_DONE exit path directly.
- **WAIT_DONE**: when `tx_busy` = 0, go to LOAD if the captured last flag is 0. If the last flag is 1, go to GAP and clear `grant`.
- **GAP**: hold for FRAME_GAP cycles, then go to IDLE. When FRAME_GAP = 0, go straight to IDLE.
- A byte with `req_last` = 1 is a one-byte frame and is legal.
- `write_data` holds its value between strobes.

## Timing
- Request to `write_en` latency from IDLE: valid at cycle t → ARB at t+1 → LOAD at t+2 with `req_ready` high → `write_en` at t+3.
- Between bytes of one frame: `tx_busy` falls at cycle u → LOAD at u+1 → `write_en` at u+2.
- `req_ready` and `write_en` are never both high in the same cycle.
- `write_en` is never asserted while the arbiter is in WAIT_BUSY or WAIT_DONE.
- `tx_busy` is sampled directly; it comes from the same clock domain.
- Asserting `rst` mid-frame aborts the frame immediately. Every output returns to its reset value, with no completion of the frame.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`
  - Defined: ARB ignores the pointer and grants the lowest-index valid requester. Requester 0 has the highest priority. The pointer is not updated.
  - Undefined: round-robin as described in Operation.

## Test plan
- Single requester 0 sends frame 8'h3D, 8'h48, 8'h0A (last); `tx_busy` model is high 10 cycles starting 1 cycle after `write_en`. Required: three `write_en` pulses carrying those bytes in order, `grant` = 01, then `grant` = 00 after FRAME_GAP cycles.
- Requesters 0 and 1 both hold 2-byte frames continuously (round-robin build). Required: grant order 0, 1, 0, 1, with no byte of one frame interleaved into the other.
- Requester 1 asserts valid while requester 0 is mid-frame. Required: requester 0's frame completes, then requester 1 is granted in the next ARB.
- `tx_busy` is held at 0 forever with BUSY_TIMEOUT = 8. Required: `err_timeout` pulses 8 cycles after each `write_en`, and the frame still completes.
- `rst` is asserted during WAIT_DONE of byte 2. Required: all outputs are 0 asynchronously, and the next frame after reset starts at requester 0.
- With `UART_ARB_FIXED_PRIO_EN` defined and both requesters always valid. Required: requester 0 wins every arbitration.
